// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences every access to the external 8-bit SRAM and shares it
// between the AVR upload/readback path and the SNES cartridge-bus read path.
// Each access is SETUP (1 cycle) -> STROBE (WAIT_CYCLES cycles) -> DONE (1 cycle).
// SNES wins ties unless the AVR has been passed over STARVE_LIMIT times in a row.
// All outputs come straight from registers.
// Optional build macro: SRAM_ARB_DEBUG_EN adds a registered debug[7:0] port.
module sram_arbiter #(
  parameter int ADDR_W       = 21,
  parameter int DATA_W       = 8,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              avr_req,
  input  logic              avr_we,
  input  logic [ADDR_W-1:0] avr_addr,
  input  logic [DATA_W-1:0] avr_wdata,
  output logic [DATA_W-1:0] avr_rdata,
  output logic              avr_ack,
  input  logic              snes_req,
  input  logic [ADDR_W-1:0] snes_addr,
  output logic [DATA_W-1:0] snes_rdata,
  output logic              snes_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              grant_snes
`ifdef SRAM_ARB_DEBUG_EN
  ,
  output logic [7:0]        debug
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Wait counter reloads with the index of the last strobe cycle.
  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES - 1);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [2:0]          starve_q, starve_d;
  logic                wr_q, wr_d;            // direction of the current transaction
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                data_oe_q, data_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [DATA_W-1:0]   avr_rdata_q, avr_rdata_d;
  logic [DATA_W-1:0]   snes_rdata_q, snes_rdata_d;
  logic                avr_ack_q, avr_ack_d;
  logic                snes_ack_q, snes_ack_d;
  logic                busy_q, busy_d;
  logic                grant_snes_q, grant_snes_d;
  logic                snes_wins;

  // SNES has priority unless the AVR is waiting and has hit the starvation limit.
  assign snes_wins = snes_req && !(avr_req && (starve_q == STARVE_MAX));

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    starve_d     = starve_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    data_oe_d    = data_oe_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    avr_rdata_d  = avr_rdata_q;
    snes_rdata_d = snes_rdata_q;
    avr_ack_d    = 1'b0;
    snes_ack_d   = 1'b0;
    busy_d       = busy_q;
    grant_snes_d = grant_snes_q;

    case (state_q)
      ST_IDLE: begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
        if (!avr_req) begin
          starve_d = '0;
        end
        if (snes_wins) begin
          // SNES path is read-only.
          grant_snes_d = 1'b1;
          wr_d         = 1'b0;
          addr_d       = snes_addr;
          ce_n_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_SETUP;
          if (avr_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
          end
        end else if (avr_req) begin
          grant_snes_d = 1'b0;
          wr_d         = avr_we;
          addr_d       = avr_addr;
          ce_n_d       = 1'b0;
          busy_d       = 1'b1;
          starve_d     = '0;
          state_d      = ST_SETUP;
          if (avr_we) begin
            dout_d    = avr_wdata;
            data_oe_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        // Address and write data have had a full cycle to settle; open the strobe.
        wait_d  = WAIT_LAST;
        state_d = ST_STROBE;
        if (wr_q) begin
          we_n_d = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
      end

      ST_STROBE: begin
        if (wait_q == 4'd0) begin
          // Last strobe edge: close strobes, deselect, capture read data, ack owner.
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          ce_n_d  = 1'b1;
          state_d = ST_DONE;
          if (grant_snes_q) begin
            snes_ack_d = 1'b1;
            if (!wr_q) begin
              snes_rdata_d = sram_din;
            end
          end else begin
            avr_ack_d = 1'b1;
            if (!wr_q) begin
              avr_rdata_d = sram_din;
            end
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_DONE: begin
        // Write data was held through DONE for hold time; release the bus now.
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces strobes inactive and the bus released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      starve_q     <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      data_oe_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      avr_rdata_q  <= '0;
      snes_rdata_q <= '0;
      avr_ack_q    <= 1'b0;
      snes_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      grant_snes_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      starve_q     <= starve_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      data_oe_q    <= data_oe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      avr_rdata_q  <= avr_rdata_d;
      snes_rdata_q <= snes_rdata_d;
      avr_ack_q    <= avr_ack_d;
      snes_ack_q   <= snes_ack_d;
      busy_q       <= busy_d;
      grant_snes_q <= grant_snes_d;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_data_oe = data_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign avr_rdata    = avr_rdata_q;
  assign snes_rdata   = snes_rdata_q;
  assign avr_ack      = avr_ack_q;
  assign snes_ack     = snes_ack_q;
  assign busy         = busy_q;
  assign grant_snes   = grant_snes_q;

`ifdef SRAM_ARB_DEBUG_EN
  logic [7:0] debug_q;
  logic [1:0] state_bits;

  assign state_bits = state_q;

  // Registered snapshot of arbiter internals for bring-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debug_q <= '0;
    end else begin
      debug_q <= {state_bits, grant_snes_q, starve_q, avr_req, snes_req};
    end
  end

  assign debug = debug_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed scenarios plus randomized requests,
// checked every cycle against a transaction-level model (phase counter per access).
module tb_sram_arbiter;
  localparam int AW = 21;
  localparam int DW = 8;
  localparam int W  = 2;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          avr_req = 1'b0;
  logic          avr_we = 1'b0;
  logic [AW-1:0] avr_addr = '0;
  logic [DW-1:0] avr_wdata = '0;
  logic [DW-1:0] avr_rdata;
  logic          avr_ack;
  logic          snes_req = 1'b0;
  logic [AW-1:0] snes_addr = '0;
  logic [DW-1:0] snes_rdata;
  logic          snes_ack;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic [DW-1:0] sram_din = '0;
  logic          sram_data_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          busy;
  logic          grant_snes;
`ifdef SRAM_ARB_DEBUG_EN
  logic [7:0]    debug;
`endif

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .avr_req(avr_req), .avr_we(avr_we), .avr_addr(avr_addr), .avr_wdata(avr_wdata),
    .avr_rdata(avr_rdata), .avr_ack(avr_ack),
    .snes_req(snes_req), .snes_addr(snes_addr), .snes_rdata(snes_rdata), .snes_ack(snes_ack),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy), .grant_snes(grant_snes)
`ifdef SRAM_ARB_DEBUG_EN
    , .debug(debug)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pin-level SRAM and the model's view of memory contents.
  logic [DW-1:0] pin_mem [logic [AW-1:0]];
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [DW-1:0] pin_rd(input logic [AW-1:0] a);
    if (pin_mem.exists(a)) return pin_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return init_val(a);
  endfunction

  // Asynchronous SRAM: writes while we_n is low, read data presented a little after each edge.
  initial forever begin
    @(posedge clk);
    if (!sram_we_n && !sram_ce_n && sram_data_oe) pin_mem[sram_addr] = sram_dout;
    #3;
    sram_din = pin_rd(sram_addr);
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int            m_phase = 0;   // 0 idle, 1..W+2 = cycle index within the access
  int            m_starve = 0;
  logic          m_owner = 1'b0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_avr_rd = '0;
  logic [DW-1:0] m_snes_rd = '0;

  initial forever begin
    logic in_strobe, e_ce_n, e_oe_n, e_we_n, e_doe, e_aack, e_sack, e_busy;
    @(negedge clk);
    if (!reset_n) begin
      m_phase = 0; m_starve = 0; m_owner = 1'b0; m_write = 1'b0;
      m_addr = '0; m_wdata = '0; m_avr_rd = '0; m_snes_rd = '0;
    end
    in_strobe = (m_phase >= 2) && (m_phase <= W + 1);
    e_ce_n = !((m_phase >= 1) && (m_phase <= W + 1));
    e_oe_n = !(in_strobe && !m_write);
    e_we_n = !(in_strobe && m_write);
    e_doe  = m_write && (m_phase != 0);
    e_aack = (m_phase == W + 2) && !m_owner;
    e_sack = (m_phase == W + 2) && m_owner;
    e_busy = (m_phase != 0);
    chk("ce_n", 32'(sram_ce_n), 32'(e_ce_n));
    chk("oe_n", 32'(sram_oe_n), 32'(e_oe_n));
    chk("we_n", 32'(sram_we_n), 32'(e_we_n));
    chk("data_oe", 32'(sram_data_oe), 32'(e_doe));
    chk("avr_ack", 32'(avr_ack), 32'(e_aack));
    chk("snes_ack", 32'(snes_ack), 32'(e_sack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_snes", 32'(grant_snes), 32'(m_owner));
    chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("avr_rdata", 32'(avr_rdata), 32'(m_avr_rd));
    chk("snes_rdata", 32'(snes_rdata), 32'(m_snes_rd));
    chk("we_oe_overlap", 32'(!sram_we_n && !sram_oe_n), 32'(0));
    if (e_doe) chk("sram_dout", 32'(sram_dout), 32'(m_wdata));
    if (reset_n) begin
      if (m_phase == 0) begin
        if (!avr_req) m_starve = 0;
        if (snes_req && !(avr_req && m_starve == SL)) begin
          m_owner = 1'b1; m_write = 1'b0; m_addr = snes_addr; m_phase = 1;
          if (avr_req && m_starve < SL) m_starve++;
        end else if (avr_req) begin
          m_owner = 1'b0; m_write = avr_we; m_addr = avr_addr; m_phase = 1; m_starve = 0;
          if (avr_we) m_wdata = avr_wdata;
        end
      end else if (m_phase == W + 1) begin
        if (m_write) mdl_mem[m_addr] = m_wdata;
        else if (m_owner) m_snes_rd = mdl_rd(m_addr);
        else m_avr_rd = mdl_rd(m_addr);
        m_phase++;
      end else if (m_phase == W + 2) begin
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int       we_low = 0, oe_low = 0, doe_hi = 0, avr_cnt = 0;
  logic     avr_seen = 1'b0, snes_hold = 1'b0;
  logic [DW-1:0] avr_rd_seen = '0, snes_rd_seen = '0;
  logic     gs_at_avr = 1'b0, gs_at_snes = 1'b0;
  logic     ack_log [$];

  // One clock: sample outputs 2 time units after the edge and run the requester handshakes.
  task automatic tick();
    @(posedge clk);
    #2;
    if (!sram_we_n) we_low++;
    if (!sram_oe_n) oe_low++;
    if (sram_data_oe) doe_hi++;
    if (avr_ack) begin
      avr_seen = 1'b1; avr_rd_seen = avr_rdata; gs_at_avr = grant_snes;
      avr_cnt++; ack_log.push_back(1'b0);
      avr_req = 1'b0;
    end
    if (snes_ack) begin
      snes_rd_seen = snes_rdata; gs_at_snes = grant_snes;
      ack_log.push_back(1'b1);
      if (!snes_hold) snes_req = 1'b0;
    end
  endtask

  task automatic wait_avr(input int maxc, output int lat);
    lat = 0;
    avr_seen = 1'b0;
    while (!avr_seen && lat < maxc) begin
      tick();
      lat++;
    end
    if (!avr_seen) chk("avr_ack_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic exp_pat [11];
    logic raised2;
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    pin_mem[21'h00010] = 8'h33;
    mdl_mem[21'h00010] = 8'h33;

    // Reset values
    repeat (3) tick();
    chk("rst_ce_n", 32'(sram_ce_n), 32'(1));
    chk("rst_oe_n", 32'(sram_oe_n), 32'(1));
    chk("rst_we_n", 32'(sram_we_n), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_addr", 32'(sram_addr), 32'(0));
`ifdef SRAM_ARB_DEBUG_EN
    chk("rst_debug", 32'(debug), 32'(0));
`endif
    reset_n = 1'b1;
    tick();

    // Reset in the middle of an AVR write strobe aborts it with no ack.
    avr_we = 1'b1; avr_addr = 21'h00055; avr_wdata = 8'hC3; avr_req = 1'b1;
    n = 0;
    while (sram_we_n && n < 10) begin tick(); n++; end
    chk("abort_reached_strobe", 32'(sram_we_n), 32'(0));
    n = avr_cnt;
    reset_n = 1'b0;
    avr_req = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'(1));
    chk("abort_ce_n", 32'(sram_ce_n), 32'(1));
    chk("abort_data_oe", 32'(sram_data_oe), 32'(0));
    chk("abort_avr_ack", 32'(avr_ack), 32'(0));
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_no_ack", 32'(avr_cnt), 32'(n));

    // AVR write 0x5A to 0x1ABCD
    avr_we = 1'b1; avr_addr = 21'h1ABCD; avr_wdata = 8'h5A; avr_req = 1'b1;
    we_low = 0; oe_low = 0; doe_hi = 0;
    wait_avr(20, lat);
    chk("wr_latency", 32'(lat), 32'(4));
    chk("wr_we_low_cycles", 32'(we_low), 32'(2));
    chk("wr_oe_low_cycles", 32'(oe_low), 32'(0));
    chk("wr_data_oe_cycles", 32'(doe_hi), 32'(4));
    tick();
    chk("wr_mem_content", 32'(pin_rd(21'h1ABCD)), 32'(8'h5A));
    chk("wr_data_oe_released", 32'(sram_data_oe), 32'(0));

    // AVR read back
    avr_we = 1'b0; avr_addr = 21'h1ABCD; avr_req = 1'b1;
    we_low = 0; oe_low = 0;
    wait_avr(20, lat);
    chk("rd_latency", 32'(lat), 32'(4));
    chk("rd_oe_low_cycles", 32'(oe_low), 32'(2));
    chk("rd_we_low_cycles", 32'(we_low), 32'(0));
    chk("rd_avr_rdata", 32'(avr_rd_seen), 32'(8'h5A));
    tick();

    // Simultaneous requests: SNES first, then AVR
    ack_log.delete();
    snes_addr = 21'h00010; snes_req = 1'b1;
    avr_we = 1'b0; avr_addr = 21'h1ABCD; avr_req = 1'b1;
    n = 0;
    while (ack_log.size() < 2 && n < 40) begin tick(); n++; end
    chk("tie_ack_count", 32'(ack_log.size()), 32'(2));
    if (ack_log.size() >= 2) begin
      chk("tie_first_snes", 32'(ack_log[0]), 32'(1));
      chk("tie_second_avr", 32'(ack_log[1]), 32'(0));
    end
    chk("tie_snes_rdata", 32'(snes_rd_seen), 32'(8'h33));
    chk("tie_grant_snes_at_snes_ack", 32'(gs_at_snes), 32'(1));
    chk("tie_grant_snes_at_avr_ack", 32'(gs_at_avr), 32'(0));
    chk("tie_avr_rdata", 32'(avr_rd_seen), 32'(8'h5A));
    tick();

    // Starvation: SNES held continuously, AVR forced in after 4 SNES grants, twice.
    ack_log.delete();
    n = avr_cnt;
    snes_hold = 1'b1; snes_addr = 21'h00100; snes_req = 1'b1;
    avr_we = 1'b0; avr_addr = 21'h00101; avr_req = 1'b1;
    raised2 = 1'b0;
    lat = 0;
    while (ack_log.size() < 11 && lat < 200) begin
      tick();
      lat++;
      if (avr_cnt == n + 1 && !raised2 && !avr_req) begin
        avr_req = 1'b1;
        raised2 = 1'b1;
      end
    end
    chk("starve_ack_count", 32'(ack_log.size()), 32'(11));
    for (int i = 0; i < 11; i++) begin
      if (i < ack_log.size()) chk($sformatf("starve_order_%0d", i), 32'(ack_log[i]), 32'(exp_pat[i]));
    end
    snes_hold = 1'b0;
    snes_req = 1'b0;
    repeat (4) tick();

    // Randomized traffic against the model
    for (int it = 0; it < 800; it++) begin
      tick();
      if (!avr_req && $urandom_range(0, 2) == 0) begin
        avr_we = 1'($urandom_range(0, 1));
        avr_addr = 21'h00100 + 21'($urandom_range(0, 15));
        avr_wdata = 8'($urandom);
        avr_req = 1'b1;
      end
      if (!snes_req && $urandom_range(0, 2) == 0) begin
        snes_addr = 21'h00100 + 21'($urandom_range(0, 15));
        snes_req = 1'b1;
      end
    end
    n = 0;
    while ((avr_req || snes_req || busy) && n < 60) begin tick(); n++; end
    chk("drain_idle", 32'(avr_req || snes_req || busy), 32'(0));
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences all accesses to the external 8-bit SRAM and shares it between two requesters: the AVR upload/readback path and the SNES cartridge-bus read path.
- Each transaction is a fixed SETUP/STROBE/DONE cycle with a programmable strobe length.
- Sits in the CPLD top level between the requester front ends and the SRAM pins. It replaces direct wiring of the SRAM strobes from AVR control lines.

Parameters:
ADDR_W, 21, SRAM address width
DATA_W, 8, SRAM data width
WAIT_CYCLES, 2, cycles oe_n/we_n held low per access (legal range 1..15)
STARVE_LIMIT, 4, consecutive SNES grants allowed while AVR is pending before AVR is forced in (legal range 1..7)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
avr_req  in  1  AVR access request, level; held until avr_ack
avr_we  in  1  1=write, 0=read; sampled at grant
avr_addr  in  ADDR_W  AVR address; stable while avr_req
avr_wdata  in  DATA_W  AVR write data; stable while avr_req
avr_rdata  out  DATA_W  AVR read data; valid from avr_ack until next AVR read completes
avr_ack  out  1  one-cycle completion pulse
snes_req  in  1  SNES read request, level; held until snes_ack
snes_addr  in  ADDR_W  SNES address; stable while snes_req
snes_rdata  out  DATA_W  SNES read data; same validity rule as avr_rdata
snes_ack  out  1  one-cycle completion pulse
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  DATA_W  data toward SRAM
sram_din  in  DATA_W  data from SRAM
sram_data_oe  out  1  tristate enable for sram_dout (1=drive)
sram_ce_n  out  1  SRAM chip enable, active low
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low
busy  out  1  1 whenever state != IDLE
grant_snes  out  1  owner of current or last transaction (1=SNES)

Behaviour:
- All outputs are registered.
- Reset values:
  - sram_ce_n, sram_oe_n and sram_we_n are 1.
  - sram_data_oe, avr_ack, snes_ack, busy and grant_snes are 0.
  - sram_addr, sram_dout, avr_rdata, snes_rdata and the starve counter are 0.
  - State is IDLE.
- States: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
- IDLE: sample requests.
  - snes_req wins when both are high, unless starve_cnt == STARVE_LIMIT; then AVR wins.
  - On grant: latch address, direction and write data; set grant_snes; go to SETUP.
  - No request: stay in IDLE with all strobes high.
- SETUP (1 cycle):
  - sram_ce_n=0, sram_addr valid, oe_n/we_n still 1.
  - For an AVR write, sram_data_oe=1 and sram_dout=wdata.
- STROBE (WAIT_CYCLES cycles, counted by wait counter):
  - Read: oe_n=0. Write: we_n=0.
  - Read data is captured from sram_din on the last STROBE edge into the owner's rdata register.
- DONE (1 cycle):
  - oe_n=we_n=1; ce_n=1; sram_addr held.
  - sram_data_oe stays 1 for writes (hold time).
  - Owner's ack=1.
  - Unconditional return to IDLE, where sram_data_oe returns to 0.
- Latency: ack is high in the (WAIT_CYCLES+2)th cycle after the IDLE edge that sampled req. With default 2, that is 4 cycles.
- Handshake: the requester drops req on the edge where it sees ack=1. A req still high in IDLE is treated as a new transaction.
- SNES path is read-only; no SNES write exists.
- Starve counter:
  - Increments on each SNES grant while avr_req=1.
  - Clears on any AVR grant, or in IDLE when avr_req=0.
  - Saturates at STARVE_LIMIT.
- Request changes after grant are ignored until DONE.
- Reset mid-transaction: strobes and ce_n go high immediately (async), and sram_data_oe goes low. The transaction is aborted with no ack; the requester must reissue.
- Writes never overlap oe_n=0. we_n and oe_n are never low simultaneously.

Optional Feature:
- SRAM_ARB_DEBUG_EN defined:
  - Adds output debug[7:0] = {state[1:0], grant_snes, starve_cnt[2:0], avr_req, snes_req}, registered.
  - Reset value 0.
- Not defined: debug port and its register are absent. Arbitration behaviour is identical in both cases.

Test Plan:
- Reset asserted mid-STROBE of an AVR write -> same cycle: we_n=1, ce_n=1, sram_data_oe=0; no avr_ack; after release state is IDLE and busy=0.
- AVR write addr 0x1ABCD, data 0x5A, WAIT_CYCLES=2 -> SETUP 1 cycle, we_n low for exactly 2 cycles, data driven SETUP through DONE, avr_ack 1 cycle 4 clocks after grant; SRAM model holds 0x5A at 0x1ABCD.
- AVR read of 0x1ABCD after write -> oe_n low 2 cycles, avr_rdata=0x5A at avr_ack, we_n stays 1 throughout.
- avr_req and snes_req rise same cycle (SNES addr 0x00010 holding 0x33) -> SNES served first with snes_rdata=0x33, grant_snes=1; AVR served in the next transaction, grant_snes=0.
- snes_req held continuously with avr_req high, STARVE_LIMIT=4 -> exactly 4 SNES acks, then 1 AVR ack, then SNES resumes; starve counter returns to 0.
